// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared CPU types: word, RAM handshake state and the memory
//            responder's state encoding (exported so benches can probe it).
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // RAM handshake state reported by the memory model / controller.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory responder control states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DACC   = 3'd1,
        IACC   = 3'd2,
        DDONE  = 3'd3,
        IDONE  = 3'd4,
        HALTED = 3'd5
    } resp_state_t;

    // The RAM is word addressed; the byte offset is always dropped.
    function automatic word_t word_align(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_if
// Purpose  : Datapath <-> memory responder request/hit bundle.
//            master = datapath side, slave = responder side.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  halt;
    logic  ihit;
    logic  dhit;
    word_t imemload;
    word_t dmemload;

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        input  ihit, dhit, imemload, dmemload
    );

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        output ihit, dhit, imemload, dmemload
    );

endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Serialises datapath fetch / data requests onto one single-port
//            variable-latency RAM. Data requests win over fetches. Provides
//            halt drain, access timeout, sticky RAM-error flag and counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  wire logic             CLK,
    input  wire logic             nRST,
    mem_responder_if.slave        dcif,
    output      logic             ramREN,
    output      logic             ramWEN,
    output      word_t            ramaddr,
    output      word_t            ramstore,
    input  wire ramstate_t        ramstate,
    input  wire word_t            ramload,
    output      logic             timeout,
    output      logic             ram_err,
    output      logic [CNT_W-1:0] icount,
    output      logic [CNT_W-1:0] dcount
);

    // Timer only needs to reach TIMEOUT-1 before the access is abandoned.
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    resp_state_t      state_q,   state_d;
    logic             wr_q,      wr_d;
    word_t            addr_q,    addr_d;
    word_t            store_q,   store_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    word_t            iload_q,   iload_d;
    word_t            dload_q,   dload_d;
    logic [CNT_W-1:0] icount_q,  icount_d;
    logic [CNT_W-1:0] dcount_q,  dcount_d;
    logic             timeout_q, timeout_d;
    logic             ram_err_q, ram_err_d;

    // State and datapath registers; async reset returns everything to zero.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
            timer_q   <= '0;
            iload_q   <= '0;
            dload_q   <= '0;
            icount_q  <= '0;
            dcount_q  <= '0;
            timeout_q <= 1'b0;
            ram_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            timer_q   <= timer_d;
            iload_q   <= iload_d;
            dload_q   <= dload_d;
            icount_q  <= icount_d;
            dcount_q  <= dcount_d;
            timeout_q <= timeout_d;
            ram_err_q <= ram_err_d;
        end
    end

    // Next-state, request latching, load capture, timer and counter updates.
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        store_d   = store_q;
        timer_d   = '0;
        iload_d   = iload_q;
        dload_d   = dload_q;
        icount_d  = icount_q;
        dcount_d  = dcount_q;
        timeout_d = timeout_q;
        ram_err_d = ram_err_q;

        case (state_q)
            IDLE: begin
                if (dcif.halt) begin
                    state_d = HALTED;
                end else if (dcif.dmemREN || dcif.dmemWEN) begin
                    // Write wins when both data strobes are raised.
                    state_d = DACC;
                    wr_d    = dcif.dmemWEN;
                    addr_d  = word_align(dcif.dmemaddr);
                    store_d = dcif.dmemstore;
                end else if (dcif.imemREN) begin
                    state_d = IACC;
                    wr_d    = 1'b0;
                    addr_d  = word_align(dcif.imemaddr);
                end
            end
            DACC, IACC: begin
                timer_d = timer_q + TMR_W'(1);
                if (ramstate == ACCESS) begin
                    if (state_q == IACC) begin
                        iload_d = ramload;
                        state_d = IDONE;
                    end else begin
                        if (!wr_q) begin
                            dload_d = ramload;
                        end
                        state_d = DDONE;
                    end
                end else if (ramstate == ERROR) begin
                    // Request is still held by the datapath, so IDLE retries.
                    ram_err_d = 1'b1;
                    state_d   = IDLE;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            DDONE: begin
                dcount_d = dcount_q + CNT_W'(1);
                state_d  = IDLE;
            end
            IDONE: begin
                icount_d = icount_q + CNT_W'(1);
                state_d  = IDLE;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM side is driven only while an access is in flight.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state_q == DACC || state_q == IACC) begin
            ramaddr = addr_q;
            if (state_q == DACC && wr_q) begin
                ramWEN   = 1'b1;
                ramstore = store_q;
            end else begin
                ramREN = 1'b1;
            end
        end
    end

    assign dcif.ihit     = (state_q == IDONE);
    assign dcif.dhit     = (state_q == DDONE);
    assign dcif.imemload = iload_q;
    assign dcif.dmemload = dload_q;
    assign timeout       = timeout_q;
    assign ram_err       = ram_err_q;
    assign icount        = icount_q;
    assign dcount        = dcount_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder (TIMEOUT=4) with a
//            hit scoreboard fed as requests are issued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    ramstate_t   ramstate;
    word_t       ramload;
    logic        ramREN, ramWEN;
    word_t       ramaddr, ramstore;
    logic        timeout, ram_err;
    logic [31:0] icount, dcount;

    mem_responder_if dcif ();

    mem_responder #(.TIMEOUT(4), .CNT_W(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .dcif     (dcif.slave),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramstate (ramstate),
        .ramload  (ramload),
        .timeout  (timeout),
        .ram_err  (ram_err),
        .icount   (icount),
        .dcount   (dcount)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic  is_d;
        word_t data;
    } exp_t;

    exp_t  sb[$];
    int    vectors     = 0;
    int    miscompares = 0;
    word_t exp_dload   = '0;
    word_t exp_iload   = '0;
    int    exp_ic      = 0;
    int    exp_dc      = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: every hit must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (nRST && (dcif.ihit || dcif.dhit)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_hit", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("hit_exclusive", dcif.ihit & dcif.dhit, 0);
                check_eq("hit_kind", dcif.dhit, e.is_d);
                check_eq(e.is_d ? "dmemload" : "imemload",
                         e.is_d ? dcif.dmemload : dcif.imemload, e.data);
            end
        end
    end

    task automatic drop_reqs();
        dcif.imemREN = 1'b0;
        dcif.dmemREN = 1'b0;
        dcif.dmemWEN = 1'b0;
    endtask

    task automatic check_counts();
        check_eq("icount", icount, exp_ic);
        check_eq("dcount", dcount, exp_dc);
    endtask

    // One complete access with `busy` BUSY cycles before ACCESS.
    task automatic access(input bit is_d, input bit wr, input word_t addr,
                          input word_t wdata, input word_t rdata, input int busy);
        exp_t e;
        @(negedge CLK);
        if (is_d) begin
            dcif.dmemREN   = !wr;
            dcif.dmemWEN   = wr;
            dcif.dmemaddr  = addr;
            dcif.dmemstore = wdata;
        end else begin
            dcif.imemREN  = 1'b1;
            dcif.imemaddr = addr;
        end
        ramload  = rdata;
        ramstate = FREE;
        if (is_d && !wr) exp_dload = rdata;
        if (!is_d)       exp_iload = rdata;
        e.is_d = is_d;
        e.data = is_d ? exp_dload : exp_iload;
        sb.push_back(e);
        for (int i = 0; i <= busy; i++) begin
            @(negedge CLK);
            check_eq("strobe", (is_d && wr) ? ramWEN : ramREN, 1);
            check_eq("other_strobe", (is_d && wr) ? ramREN : ramWEN, 0);
            check_eq("ramaddr", ramaddr, addr & 32'hFFFF_FFFC);
            if (is_d && wr) check_eq("ramstore", ramstore, wdata);
            check_eq("early_hit", dcif.ihit | dcif.dhit, 0);
            ramstate = (i < busy) ? BUSY : ACCESS;
        end
        @(negedge CLK);
        check_eq("hit", is_d ? dcif.dhit : dcif.ihit, 1);
        check_eq("strobe_off", ramREN | ramWEN, 0);
        drop_reqs();
        ramstate = FREE;
        if (is_d) exp_dc++; else exp_ic++;
        @(negedge CLK);
        check_counts();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        drop_reqs();
        dcif.imemaddr  = '0;
        dcif.dmemaddr  = '0;
        dcif.dmemstore = '0;
        dcif.halt      = 1'b0;
        ramstate       = FREE;
        ramload        = '0;

        // Reset values
        repeat (3) @(negedge CLK);
        check_eq("rst_strobes", {ramREN, ramWEN, dcif.ihit, dcif.dhit}, 0);
        check_eq("rst_flags", {timeout, ram_err}, 0);
        check_eq("rst_loads", {dcif.imemload, dcif.dmemload}, 0);
        check_counts();
        nRST = 1'b1;

        // Read with 3-cycle RAM latency
        access(1, 0, 32'h104, 32'h0, 32'hDEADBEEF, 2);

        // Write and fetch raised together: write first
        @(negedge CLK);
        dcif.dmemWEN   = 1'b1;
        dcif.dmemaddr  = 32'h500;
        dcif.dmemstore = 32'h55;
        dcif.imemREN   = 1'b1;
        dcif.imemaddr  = 32'h600;
        ramload        = 32'h600D600D;
        e = '{is_d: 1'b1, data: exp_dload};
        sb.push_back(e);
        exp_iload = 32'h600D600D;
        e = '{is_d: 1'b0, data: exp_iload};
        sb.push_back(e);
        @(negedge CLK);
        check_eq("prio_wen", {ramWEN, ramREN}, 2'b10);
        check_eq("prio_store", ramstore, 32'h55);
        check_eq("prio_addr", ramaddr, 32'h500);
        ramstate = ACCESS;
        @(negedge CLK);
        check_eq("prio_dhit", dcif.dhit, 1);
        dcif.dmemWEN = 1'b0;
        ramstate     = FREE;
        @(negedge CLK);
        check_eq("prio_gap", ramREN | ramWEN, 0);
        @(negedge CLK);
        check_eq("prio_fetch", ramREN, 1);
        check_eq("prio_faddr", ramaddr, 32'h600);
        ramstate = ACCESS;
        @(negedge CLK);
        check_eq("prio_ihit", dcif.ihit, 1);
        drop_reqs();
        ramstate = FREE;
        exp_ic++;
        exp_dc++;
        @(negedge CLK);
        check_counts();

        // Unaligned fetch, immediate ACCESS
        access(0, 0, 32'h0000000B, 32'h0, 32'h13579BDF, 0);

        // Timeout after 4 BUSY cycles, then retry succeeds
        check_eq("timeout_pre", timeout, 0);
        @(negedge CLK);
        dcif.dmemREN  = 1'b1;
        dcif.dmemaddr = 32'h300;
        ramstate      = BUSY;
        ramload       = 32'hCAFEF00D;
        exp_dload     = 32'hCAFEF00D;
        e = '{is_d: 1'b1, data: exp_dload};
        sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check_eq("to_strobe", ramREN, 1);
        end
        @(negedge CLK);
        check_eq("to_drop", ramREN, 0);
        check_eq("to_flag", timeout, 1);
        check_eq("to_nohit", dcif.dhit, 0);
        ramstate = ACCESS;
        @(negedge CLK);
        check_eq("to_retry", ramREN, 1);
        @(negedge CLK);
        check_eq("to_dhit", dcif.dhit, 1);
        drop_reqs();
        ramstate = FREE;
        exp_dc++;
        @(negedge CLK);
        check_eq("to_sticky", timeout, 1);
        check_counts();

        // RAM error during a fetch, retried from IDLE
        check_eq("err_pre", ram_err, 0);
        @(negedge CLK);
        dcif.imemREN  = 1'b1;
        dcif.imemaddr = 32'h400;
        ramload       = 32'h0BADF00D;
        exp_iload     = 32'h0BADF00D;
        e = '{is_d: 1'b0, data: exp_iload};
        sb.push_back(e);
        @(negedge CLK);
        check_eq("err_strobe", ramREN, 1);
        ramstate = ERROR;
        @(negedge CLK);
        check_eq("err_drop", ramREN, 0);
        check_eq("err_flag", ram_err, 1);
        check_eq("err_nohit", dcif.ihit, 0);
        ramstate = ACCESS;
        @(negedge CLK);
        check_eq("err_retry", ramREN, 1);
        check_eq("err_addr", ramaddr, 32'h400);
        @(negedge CLK);
        check_eq("err_ihit", dcif.ihit, 1);
        drop_reqs();
        ramstate = FREE;
        exp_ic++;
        @(negedge CLK);
        check_counts();

        // Reset in the middle of an access
        dcif.dmemREN  = 1'b1;
        dcif.dmemaddr = 32'h700;
        @(negedge CLK);
        check_eq("mid_strobe", ramREN, 1);
        #1 nRST = 1'b0;
        #1;
        check_eq("mid_rst_strobe", ramREN, 0);
        check_eq("mid_rst_cnt", {icount, dcount}, 0);
        check_eq("mid_rst_flags", {timeout, ram_err}, 0);
        drop_reqs();
        exp_ic = 0; exp_dc = 0; exp_dload = '0; exp_iload = '0;
        @(negedge CLK);
        check_eq("mid_rst_nohit", dcif.dhit | dcif.ihit, 0);
        nRST = 1'b1;

        // Halt during an access: access completes, then HALTED
        @(negedge CLK);
        dcif.dmemREN  = 1'b1;
        dcif.dmemaddr = 32'h200;
        ramload       = 32'h12345678;
        exp_dload     = 32'h12345678;
        e = '{is_d: 1'b1, data: exp_dload};
        sb.push_back(e);
        @(negedge CLK);
        check_eq("halt_strobe", ramREN, 1);
        dcif.halt = 1'b1;
        ramstate  = ACCESS;
        @(negedge CLK);
        check_eq("halt_dhit", dcif.dhit, 1);
        drop_reqs();
        ramstate = FREE;
        exp_dc++;
        @(negedge CLK);
        @(negedge CLK);
        check_eq("halt_state", dut.state_q, HALTED);
        dcif.imemREN  = 1'b1;
        dcif.imemaddr = 32'h800;
        ramstate      = ACCESS;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check_eq("halted_quiet", {ramREN, ramWEN, dcif.ihit, dcif.dhit}, 0);
        end
        check_counts();
        #1 nRST = 1'b0;
        #1;
        check_eq("final_rst_outs", {ramREN, ramWEN, dcif.ihit, dcif.dhit, timeout, ram_err}, 0);
        check_eq("final_rst_loads", {dcif.imemload, dcif.dmemload}, 0);
        check_eq("final_rst_cnt", {icount, dcount}, 0);
        check_eq("final_rst_state", dut.state_q, IDLE);
        check_eq("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
